// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - host-side bundle for the UART transmitter
//
// Groups the transmit request, frame configuration and serial/status outputs.
//   tx_start     : transmit request, sampled on tx_tick edges
//   tx_din       : data byte, bit 0 sent first
//   frame_length : data bits per frame (5..8, anything else means 8)
//   parity_type  : 0 = even, 1 = odd
//   parity_en    : 1 = append a parity bit
//   stop2        : 0 = one stop bit, 1 = two stop bits
//   tx           : serial line, idles high
//   tx_busy      : high while a frame is in progress
//   tx_done      : one-tick pulse on the edge that completes a frame
// master = host logic driving requests, slave = the transmitter.
interface uart_transmitter_if;
    logic       tx_start;
    logic [7:0] tx_din;
    logic [3:0] frame_length;
    logic       parity_type;
    logic       parity_en;
    logic       stop2;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start,
        output tx_din,
        output frame_length,
        output parity_type,
        output parity_en,
        output stop2,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_din,
        input  frame_length,
        input  parity_type,
        input  parity_en,
        input  stop2,
        output tx,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART serialiser: start, 5-8 data bits LSB first, optional parity, 1/2 stops
//
// Ports:
//   tx_tick : baud-rate tick; every rising edge starts one bit period
//   reset   : asynchronous, active-high reset
//   bus     : uart_transmitter_if.slave (request, frame format, tx/tx_busy/tx_done)
//
// The request and frame format are captured into shadow registers on the
// edge that accepts tx_start, so the host may change its inputs mid-frame.
// The start bit is driven on that same edge. All outputs are registered.
module uart_transmitter (
    input logic               tx_tick,
    input logic               reset,
    uart_transmitter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t     state;

    // Shadow copy of the frame being sent.
    logic [7:0] data_q;
    logic [3:0] len_q;
    logic       ptype_q;
    logic       pen_q;
    logic       stop2_q;

    // bit_cnt = number of data bits already placed on the line.
    logic [3:0] bit_cnt;
    // Set once the first of two stop periods has elapsed.
    logic       stop_cnt;

    logic       tx_q;
    logic       busy_q;
    logic       done_q;

    logic [3:0] eff_len;
    logic       parity_bit;
    logic       last_stop;
    logic       take_start;

    // Out-of-range lengths fall back to a full byte.
    always_comb begin
        eff_len = 4'd8;
        if (bus.frame_length >= 4'd5 && bus.frame_length <= 4'd8) begin
            eff_len = bus.frame_length;
        end
    end

    // Parity covers only the bits actually sent; odd parity inverts the XOR.
    always_comb begin
        parity_bit = ptype_q;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < len_q) begin
                parity_bit = parity_bit ^ data_q[i];
            end
        end
    end

    // The edge ending the final stop period can accept a new request, which
    // gives back-to-back frames with no idle gap.
    always_comb begin
        last_stop  = (state == STOP) && (!stop2_q || stop_cnt);
        take_start = bus.tx_start && ((state == IDLE) || last_stop);
    end

    always_ff @(posedge tx_tick or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            data_q   <= 8'd0;
            len_q    <= 4'd0;
            ptype_q  <= 1'b0;
            pen_q    <= 1'b0;
            stop2_q  <= 1'b0;
            bit_cnt  <= 4'd0;
            stop_cnt <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;

            case (state)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end

                START: begin
                    tx_q    <= data_q[0];
                    bit_cnt <= 4'd1;
                    state   <= DATA;
                end

                DATA: begin
                    if (bit_cnt == len_q) begin
                        if (pen_q) begin
                            tx_q  <= parity_bit;
                            state <= PARITY;
                        end else begin
                            tx_q     <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= STOP;
                        end
                    end else begin
                        // bit_cnt is at most 7 here, so the low three bits index the byte.
                        tx_q    <= data_q[bit_cnt[2:0]];
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end

                PARITY: begin
                    tx_q     <= 1'b1;
                    stop_cnt <= 1'b0;
                    state    <= STOP;
                end

                STOP: begin
                    tx_q <= 1'b1;
                    if (last_stop) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        stop_cnt <= 1'b1;
                    end
                end

                default: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase

            // Accepting a request overrides whatever the case above chose:
            // start bit goes out on this edge and busy stays asserted.
            if (take_start) begin
                data_q   <= bus.tx_din;
                len_q    <= eff_len;
                ptype_q  <= bus.parity_type;
                pen_q    <= bus.parity_en;
                stop2_q  <= bus.stop2;
                bit_cnt  <= 4'd0;
                stop_cnt <= 1'b0;
                tx_q     <= 1'b0;
                busy_q   <= 1'b1;
                state    <= START;
            end
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - scoreboard testbench for uart_transmitter
module tb_uart_transmitter;

    logic tx_tick;
    logic reset;

    uart_transmitter_if bus ();

    uart_transmitter dut (
        .tx_tick (tx_tick),
        .reset   (reset),
        .bus     (bus.slave)
    );

    initial begin
        tx_tick = 1'b0;
        forever #5 tx_tick = ~tx_tick;
    end

    typedef struct {
        logic [11:0] bits;
        int          n;
    } frame_t;

    frame_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Monitor: collect line levels while busy; a tx_done pulse closes the frame.
    logic [11:0] cap = '0;
    int          cap_n = 0;
    logic        prev_done = 1'b0;

    always @(negedge tx_tick) begin
        frame_t e;
        if (bus.tx_done) begin
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_width: tx_done high for more than one tick");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame_unexpected: got bits=%b n=%0d, required no frame", cap, cap_n);
            end else begin
                e = exp_q.pop_front();
                if (cap_n != e.n || cap != e.bits) begin
                    errors++;
                    $display("FAIL frame: got bits=%b n=%0d, required bits=%b n=%0d",
                             cap, cap_n, e.bits, e.n);
                end
            end
            cap   = '0;
            cap_n = 0;
        end else if (!bus.tx_busy) begin
            cap   = '0;
            cap_n = 0;
        end
        if (bus.tx_busy) begin
            cap   = {cap[10:0], bus.tx};
            cap_n = cap_n + 1;
        end
        prev_done = bus.tx_done;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic start_frame(input logic [7:0] d, input logic [3:0] fl, input logic pen,
                               input logic pt, input logic s2, input logic [11:0] eb,
                               input int n, input bit push);
        frame_t f;
        @(negedge tx_tick);
        bus.tx_din       = d;
        bus.frame_length = fl;
        bus.parity_en    = pen;
        bus.parity_type  = pt;
        bus.stop2        = s2;
        bus.tx_start     = 1'b1;
        if (push) begin
            f.bits = eb;
            f.n    = n;
            exp_q.push_back(f);
        end
        @(negedge tx_tick);
        bus.tx_start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.tx_busy && k < 40) begin
            @(negedge tx_tick);
            k++;
        end
        checks++;
        if (bus.tx_busy) begin
            errors++;
            $display("FAIL idle_timeout: tx_busy still 1 after %0d ticks, required 0", k);
        end
    endtask

    initial begin
        int busy_cnt;

        bus.tx_start     = 1'b0;
        bus.tx_din       = 8'h00;
        bus.frame_length = 4'd8;
        bus.parity_type  = 1'b0;
        bus.parity_en    = 1'b0;
        bus.stop2        = 1'b0;
        reset            = 1'b1;
        repeat (2) @(negedge tx_tick);
        chk("reset_tx", 32'(bus.tx), 32'd1);
        chk("reset_busy", 32'(bus.tx_busy), 32'd0);
        chk("reset_done", 32'(bus.tx_done), 32'd0);
        reset = 1'b0;

        // 8N1 0xA5
        start_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 12'b0101001011, 10, 1'b1);
        wait_idle();
        // 7E1 / 7O1 0x35, bit 7 ignored
        start_frame(8'h35, 4'd7, 1'b1, 1'b0, 1'b0, 12'b0101011001, 10, 1'b1);
        wait_idle();
        start_frame(8'h35, 4'd7, 1'b1, 1'b1, 1'b0, 12'b0101011011, 10, 1'b1);
        wait_idle();
        // 5O2 0xFF
        start_frame(8'hFF, 4'd5, 1'b1, 1'b1, 1'b1, 12'b011111011, 9, 1'b1);
        wait_idle();

        // Back-to-back 0x01 then 0x80, tx_start held across the first frame.
        begin
            frame_t f;
            @(negedge tx_tick);
            bus.tx_din       = 8'h01;
            bus.frame_length = 4'd8;
            bus.parity_en    = 1'b0;
            bus.parity_type  = 1'b0;
            bus.stop2        = 1'b0;
            bus.tx_start     = 1'b1;
            f.bits = 12'b0100000001; f.n = 10; exp_q.push_back(f);
            f.bits = 12'b0000000011; f.n = 10; exp_q.push_back(f);
            busy_cnt = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge tx_tick);
                if (bus.tx_busy) busy_cnt++;
                if (i == 0) bus.tx_din = 8'h80;
                if (i == 10) bus.tx_start = 1'b0;
            end
            chk("b2b_busy_periods", 32'(busy_cnt), 32'd20);
            wait_idle();
        end

        // Illegal length -> 8 bits; mid-frame request and config change ignored.
        start_frame(8'h3C, 4'd0, 1'b0, 1'b0, 1'b0, 12'b0001111001, 10, 1'b1);
        repeat (3) @(negedge tx_tick);
        bus.tx_start     = 1'b1;
        bus.tx_din       = 8'hFF;
        bus.parity_en    = 1'b1;
        bus.frame_length = 4'd5;
        @(negedge tx_tick);
        bus.tx_start = 1'b0;
        wait_idle();

        // Reset during data bit 3, then a full 8E2 frame.
        start_frame(8'h5A, 4'd8, 1'b0, 1'b0, 1'b0, 12'd0, 0, 1'b0);
        repeat (4) @(negedge tx_tick);
        #2 reset = 1'b1;
        #1;
        chk("midreset_tx", 32'(bus.tx), 32'd1);
        chk("midreset_busy", 32'(bus.tx_busy), 32'd0);
        chk("midreset_done", 32'(bus.tx_done), 32'd0);
        repeat (2) @(negedge tx_tick);
        reset = 1'b0;
        start_frame(8'hC3, 4'd8, 1'b1, 1'b0, 1'b1, 12'b011000011011, 12, 1'b1);
        wait_idle();

        repeat (3) @(negedge tx_tick);
        chk("frames_outstanding", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
